data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 122 ++++++++++++
 tb/tb_data_mem_responder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Core-side data bus between the pipeline and the data memory responder.
interface data_mem_responder_if #(
    parameter int unsigned N = 64
);
    logic         datareq;
    logic [N-1:0] dataadr;
    logic [N-1:0] writedata;
    logic [1:0]   memwriteM;
    logic [N-1:0] readdata;
    logic         dataabort;
    logic [15:0]  xfercount;

    // Core side: issues requests, sees data and the wait request.
    modport master (
        output datareq, dataadr, writedata, memwriteM,
        input  readdata, dataabort, xfercount
    );

    // Memory side: answers requests.
    modport slave (
        input  datareq, dataadr, writedata, memwriteM,
        output readdata, dataabort, xfercount
    );
endinterface

// File: rtl/data_mem_responder.sv
// Wait-state data memory: holds the core with dataabort for a fixed latency,
// then commits the captured access once and returns the full doubleword.
module data_mem_responder #(
    parameter int unsigned N     = 64,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned LAT   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_responder_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned IW = AW + 3;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_next;
    logic           capture;
    logic           commit;

    logic [IW-1:0]  adr_q;
    logic [N-1:0]   wdata_q;
    logic [1:0]     mw_q;
    logic [N-1:0]   rdata_q;
    logic [15:0]    xfer_q;

    logic [N-1:0]   mem [DEPTH];
    logic [AW-1:0]  idx;
    logic [N-1:0]   merged;

    // Address bits above the index alias onto the array.
    logic           unused_adr;
    assign unused_adr = &{1'b0, bus.dataadr[N-1:IW]};

    assign idx = adr_q[IW-1:3];

    // The wait request rises in the same cycle as the request; only DONE releases it.
    assign bus.dataabort = bus.datareq && (state != DONE);
    assign bus.readdata  = rdata_q;
    assign bus.xfercount = xfer_q;

    // Post-access word: the stored word with the captured store lanes merged in.
    always_comb begin
        merged = mem[idx];
        case (mw_q)
            2'b01: begin
                if (adr_q[2]) merged[63:32] = wdata_q[31:0];
                else          merged[31:0]  = wdata_q[31:0];
            end
            2'b10:   merged = wdata_q;
            2'b11:   merged[{adr_q[2:0], 3'b000} +: 8] = wdata_q[7:0];
            default: ;
        endcase
    end

    // Next state: the counter loads LAT-1 and DONE is entered once it reaches
    // zero, so the stall is LAT cycles with a floor of two (IDLE + one BUSY).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.datareq) begin
                    capture    = 1'b1;
                    cnt_next   = CW'(LAT - 1);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (!bus.datareq) begin
                    state_next = IDLE;
                end else if (cnt <= CW'(1)) begin
                    cnt_next   = '0;
                    commit     = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next   = cnt - CW'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control, capture, response and transaction-count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            adr_q   <= '0;
            wdata_q <= '0;
            mw_q    <= '0;
            rdata_q <= '0;
            xfer_q  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (capture) begin
                adr_q   <= bus.dataadr[IW-1:0];
                wdata_q <= bus.writedata;
                mw_q    <= bus.memwriteM;
            end
            if (commit) rdata_q <= merged;
            if (state == DONE) xfer_q <= xfer_q + 16'd1;
        end
    end

    // Storage array: cleared on reset, written once on entry to DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (commit && (mw_q != 2'b00)) begin
            mem[idx] <= merged;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected read data queued at issue,
// popped when the wait request releases.
module tb_data_mem_responder;
    localparam int unsigned N     = 64;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;
    localparam int unsigned STALL = (LAT > 2) ? LAT : 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if #(.N(N)) bus ();

    data_mem_responder #(.N(N), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q [$];
    logic [63:0] ref_mem [DEPTH];
    logic [15:0] exp_xfer;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_merge(input logic [63:0] old, input logic [1:0] mw,
                                                input logic [63:0] adr, input logic [63:0] wd);
        logic [63:0] m;
        m = old;
        case (mw)
            2'b01: begin
                if (adr[2]) m[63:32] = wd[31:0];
                else        m[31:0]  = wd[31:0];
            end
            2'b10:   m = wd;
            2'b11:   m[8*adr[2:0] +: 8] = wd[7:0];
            default: ;
        endcase
        return m;
    endfunction

    // One full transaction; call at posedge+1. keep leaves datareq high for back-to-back use.
    task automatic xfer(input string tag, input logic [1:0] mw, input logic [63:0] adr,
                        input logic [63:0] wd, input bit scramble, input bit keep);
        int          idx;
        int          stall;
        bit          done;
        logic [63:0] nw;
        idx = int'((adr >> 3) % DEPTH);
        nw  = model_merge(ref_mem[idx], mw, adr, wd);
        exp_q.push_back(nw);
        ref_mem[idx] = nw;
        bus.datareq   = 1'b1;
        bus.memwriteM = mw;
        bus.dataadr   = adr;
        bus.writedata = wd;
        stall = 0;
        done  = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (bus.dataabort) begin
                stall++;
                if (scramble && stall == 2) begin
                    bus.dataadr   = ~adr;
                    bus.writedata = ~wd;
                    bus.memwriteM = 2'b10;
                end
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            check_eq({tag, "_timeout"}, 64'(done), 64'd1);
            bus.datareq = 1'b0;
        end else begin
            check_eq({tag, "_stall"}, 64'(stall), 64'(STALL));
            check_eq({tag, "_rdata"}, bus.readdata, exp_q.pop_front());
            exp_xfer++;
            @(posedge clk);
            #1;
            if (!keep) bus.datareq = 1'b0;
            check_eq({tag, "_xfer"}, 64'(bus.xfercount), 64'(exp_xfer));
        end
    endtask

    initial begin
        logic [63:0] held;
        bus.datareq   = 1'b0;
        bus.dataadr   = '0;
        bus.writedata = '0;
        bus.memwriteM = 2'b00;
        exp_xfer      = '0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;

        #1;
        check_eq("rst_rdata", bus.readdata, 64'd0);
        check_eq("rst_xfer",  64'(bus.xfercount), 64'd0);
        check_eq("rst_abort", 64'(bus.dataabort), 64'd0);
        #21 reset = 1'b1;
        @(posedge clk);
        #1;

        // Doubleword, word-upper and byte stores with readbacks.
        xfer("s1_dword", 2'b10, 64'h10, 64'h1122334455667788, 1'b0, 1'b0);
        check_eq("s1_lit", bus.readdata, 64'h1122334455667788);
        xfer("s2_word", 2'b01, 64'h14, 64'h00000000AABBCCDD, 1'b0, 1'b0);
        xfer("s2_read", 2'b00, 64'h10, 64'h0, 1'b0, 1'b0);
        check_eq("s2_lit", bus.readdata, 64'hAABBCCDD55667788);
        xfer("s3_byte", 2'b11, 64'h13, 64'hEE, 1'b0, 1'b0);
        xfer("s3_read", 2'b00, 64'h10, 64'h0, 1'b0, 1'b0);
        check_eq("s3_lit", bus.readdata, 64'hAABBCCDDEE667788);

        // Lower-word store with ignored low address bits, and top byte lane.
        xfer("w_low", 2'b01, 64'h1B, 64'hFFFFFFFF01020304, 1'b0, 1'b0);
        xfer("b_top", 2'b11, 64'h1F, 64'h99, 1'b0, 1'b0);
        check_eq("b_top_lit", bus.readdata, 64'h9900000001020304);

        // Store cancelled by dropping datareq in BUSY.
        held = bus.readdata;
        bus.datareq   = 1'b1;
        bus.memwriteM = 2'b10;
        bus.dataadr   = 64'h20;
        bus.writedata = 64'hDEADBEEFCAFEF00D;
        @(posedge clk);
        #1;
        bus.datareq = 1'b0;
        @(negedge clk);
        check_eq("cancel_abort", 64'(bus.dataabort), 64'd0);
        @(posedge clk);
        #1;
        check_eq("cancel_xfer",  64'(bus.xfercount), 64'(exp_xfer));
        check_eq("cancel_rdata", bus.readdata, held);
        xfer("cancel_read", 2'b00, 64'h20, 64'h0, 1'b0, 1'b0);

        // Back-to-back reads with aliasing.
        held = 64'(exp_xfer);
        xfer("alias_a", 2'b00, 64'h10,  64'h0, 1'b0, 1'b1);
        xfer("alias_b", 2'b00, 64'h810, 64'h0, 1'b0, 1'b0);
        check_eq("alias_lit",  bus.readdata, 64'hAABBCCDDEE667788);
        check_eq("alias_cnt2", 64'(bus.xfercount), held + 64'd2);

        // Inputs changed during BUSY must be ignored.
        xfer("scramble", 2'b10, 64'h30, 64'h0123456789ABCDEF, 1'b1, 1'b0);
        xfer("scramble_rd", 2'b00, 64'h30, 64'h0, 1'b0, 1'b0);

        // Asynchronous reset in BUSY.
        bus.datareq   = 1'b1;
        bus.memwriteM = 2'b10;
        bus.dataadr   = 64'h40;
        bus.writedata = 64'h5555AAAA5555AAAA;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("ares_rdata", bus.readdata, 64'd0);
        check_eq("ares_xfer",  64'(bus.xfercount), 64'd0);
        check_eq("ares_abort_req", 64'(bus.dataabort), 64'd1);
        bus.datareq = 1'b0;
        #1;
        check_eq("ares_abort_idle", 64'(bus.dataabort), 64'd0);
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        exp_xfer = '0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        xfer("post_rst_10", 2'b00, 64'h10, 64'h0, 1'b0, 1'b0);
        xfer("post_rst_40", 2'b00, 64'h40, 64'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
